// File: rtl/dp_sink_aux_responder.sv
// Sink-side AUX channel responder with DPCD byte store and HPD / IRQ_HPD generation.
// Requests arrive byte-per-clock framed by START_STOP; replies go back on the same shared bus.
module dp_sink_aux_responder #(
  parameter int unsigned                AUX_DATA_WIDTH = 8,
  parameter int unsigned                DPCD_DEPTH     = 1024,
  parameter int unsigned                MAX_LEN        = 16,
  parameter int unsigned                TURNAROUND     = 2,
  parameter int unsigned                IRQ_PULSE      = 8,
  parameter logic [AUX_DATA_WIDTH-1:0]  DPCD_REV       = 8'h14,
  parameter logic [AUX_DATA_WIDTH-1:0]  MAX_LINK_RATE  = 8'h1E,
  parameter logic [AUX_DATA_WIDTH-1:0]  MAX_LANE_COUNT = 8'h84
) (
  input  logic                           clk,
  input  logic                           rst_n,
  inout  wire logic [AUX_DATA_WIDTH-1:0] AUX_IN_OUT,
  inout  wire logic                      START_STOP,
  output logic                           HPD_Signal,
  input  logic                           hpd_connect,
  input  logic                           hpd_irq,
  input  logic                           defer_en,
  output logic                           busy
);

  localparam int unsigned ADDR_W    = $clog2(DPCD_DEPTH);
  localparam int unsigned FRAME_MAX = 4 + MAX_LEN;
  localparam int unsigned CNT_W     = $clog2(FRAME_MAX + 1);
  localparam int unsigned TMR_W     = $clog2(MAX_LEN + TURNAROUND + 1);
  localparam int unsigned IRQ_W     = $clog2(IRQ_PULSE + 1);

  localparam logic [CNT_W-1:0]  FRAME_MAX_C = CNT_W'(FRAME_MAX);
  localparam logic [TMR_W-1:0]  TA_LAST     = TMR_W'(TURNAROUND - 1);
  localparam logic [ADDR_W-1:0] RO_LIMIT    = ADDR_W'(256);
  localparam logic [20:0]       DEPTH_C     = 21'(DPCD_DEPTH);
  localparam logic [8:0]        MAX_LEN_C   = 9'(MAX_LEN);

  localparam logic [AUX_DATA_WIDTH-1:0] REPLY_ACK   = '0;
  localparam logic [AUX_DATA_WIDTH-1:0] REPLY_NACK  = AUX_DATA_WIDTH'(8'h10);
  localparam logic [AUX_DATA_WIDTH-1:0] REPLY_DEFER = AUX_DATA_WIDTH'(8'h20);
  localparam logic [3:0]                CMD_WR      = 4'b1000;
  localparam logic [3:0]                CMD_RD      = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_TURN, S_TX_HDR, S_TX_DATA, S_RELEASE
  } state_t;

  state_t state, state_next;

  logic [AUX_DATA_WIDTH-1:0] frame [FRAME_MAX];
  logic [AUX_DATA_WIDTH-1:0] dpcd  [DPCD_DEPTH];
  logic [CNT_W-1:0]          rx_cnt, rx_idx;
  logic                      ovf;
  logic                      rx_take, frame_end;
  logic [AUX_DATA_WIDTH-1:0] reply;
  logic                      rd_ack;
  logic [TMR_W-1:0]          tmr;
  logic [IRQ_W-1:0]          irq_cnt;

  logic [3:0]                cmd;
  logic [19:0]               addr;
  logic [7:0]                len;
  logic [20:0]               last_addr;
  logic [8:0]                len_p1, data_cnt;
  logic                      drop, dec_read, dec_commit;
  logic [AUX_DATA_WIDTH-1:0] dec_reply;
  logic [ADDR_W-1:0]         wr_addr [MAX_LEN];
  logic                      wr_en   [MAX_LEN];
  logic [ADDR_W-1:0]         rd_addr;

  logic                      drv, ss_out;
  logic [AUX_DATA_WIDTH-1:0] aux_out;

  assign cmd       = frame[0][7:4];
  assign addr      = {frame[0][3:0], frame[1][7:0], frame[2][7:0]};
  assign len       = frame[3][7:0];
  assign last_addr = {1'b0, addr} + {13'b0, len};
  assign len_p1    = {1'b0, len} + 9'd1;
  assign data_cnt  = 9'(rx_cnt) - 9'd4;
  assign rx_take   = START_STOP && (state == S_IDLE || state == S_RX);
  assign rx_idx    = (state == S_IDLE) ? '0 : rx_cnt;
  assign frame_end = (state == S_RX) && !START_STOP;
  assign rd_addr   = addr[ADDR_W-1:0] + ADDR_W'(tmr);

  // Reply decision, evaluated on the cycle the frame closes; earlier checks take priority.
  always_comb begin
    drop       = (rx_cnt < CNT_W'(4));
    dec_reply  = REPLY_ACK;
    dec_read   = 1'b0;
    dec_commit = 1'b0;
    if (defer_en) begin
      dec_reply = REPLY_DEFER;
    end else if (ovf || (cmd != CMD_WR && cmd != CMD_RD) || (len_p1 > MAX_LEN_C) ||
                 (last_addr >= DEPTH_C) || (cmd == CMD_WR && data_cnt != len_p1)) begin
      dec_reply = REPLY_NACK;
    end else begin
      dec_read   = (cmd == CMD_RD);
      dec_commit = (cmd == CMD_WR);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      wr_addr[i] = addr[ADDR_W-1:0] + ADDR_W'(i);
      wr_en[i]   = (8'(i) <= len) && (wr_addr[i] >= RO_LIMIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (START_STOP) state_next = S_RX;
      S_RX:      if (!START_STOP) state_next = drop ? S_IDLE : S_TURN;
      S_TURN:    if (tmr == TA_LAST) state_next = S_TX_HDR;
      S_TX_HDR:  state_next = rd_ack ? S_TX_DATA : S_RELEASE;
      S_TX_DATA: if (8'(tmr) == len) state_next = S_RELEASE;
      S_RELEASE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    drv     = 1'b0;
    ss_out  = 1'b0;
    aux_out = '0;
    unique case (state)
      S_TX_HDR:  begin drv = 1'b1; ss_out = 1'b1; aux_out = reply;         end
      S_TX_DATA: begin drv = 1'b1; ss_out = 1'b1; aux_out = dpcd[rd_addr]; end
      S_RELEASE: begin drv = 1'b1; ss_out = 1'b0; aux_out = '0;            end
      default:   ;
    endcase
  end

  assign AUX_IN_OUT = drv ? aux_out : 'z;
  assign START_STOP = drv ? ss_out  : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FRAME_MAX; i++) frame[i] <= '0;
      rx_cnt <= '0;
      ovf    <= 1'b0;
      reply  <= '0;
      rd_ack <= 1'b0;
      tmr    <= '0;
    end else begin
      // Bytes beyond the buffer are dropped but remembered so the reply becomes NACK.
      if (rx_take) begin
        if (rx_idx < FRAME_MAX_C) begin
          frame[rx_idx] <= AUX_IN_OUT;
          rx_cnt        <= rx_idx + CNT_W'(1);
        end
        ovf <= ((state == S_RX) && ovf) || (rx_idx >= FRAME_MAX_C);
      end
      if (frame_end) begin
        reply  <= dec_reply;
        rd_ack <= dec_read;
      end
      unique case (state)
        S_TURN:    tmr <= (tmr == TA_LAST) ? '0 : tmr + TMR_W'(1);
        S_TX_DATA: tmr <= tmr + TMR_W'(1);
        default:   tmr <= '0;
      endcase
    end
  end

  // Write data is committed in one cycle at frame end, so a rejected frame never touches DPCD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < DPCD_DEPTH; j++) dpcd[j] <= '0;
      dpcd[0] <= DPCD_REV;
      dpcd[1] <= MAX_LINK_RATE;
      dpcd[2] <= MAX_LANE_COUNT;
    end else if (frame_end && !drop && dec_commit) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if (wr_en[i]) dpcd[wr_addr[i]] <= frame[4+i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HPD_Signal <= 1'b0;
      irq_cnt    <= '0;
    end else if (irq_cnt != '0) begin
      irq_cnt    <= irq_cnt - IRQ_W'(1);
      HPD_Signal <= (irq_cnt == IRQ_W'(1)) ? hpd_connect : 1'b0;
    end else if (hpd_irq && HPD_Signal) begin
      irq_cnt    <= IRQ_W'(IRQ_PULSE);
      HPD_Signal <= 1'b0;
    end else begin
      HPD_Signal <= hpd_connect;
    end
  end

endmodule
